// File: rtl/i2c_eeprom_ctrl.sv
// Command sequencer for a 24Cxx-style EEPROM: turns one single-byte write or random-read
// command into start / byte-write / byte-read / stop primitives for the I2C byte PHY.
module i2c_eeprom_ctrl #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int          ADDR_BYTES = 2,
  parameter logic [15:0] TIMEOUT    = 16'd8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_write,
  input  logic        cmd_read,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic        phy_start_req,
  output logic        phy_stop_req,
  output logic        phy_write_req,
  output logic        phy_read_req,
  input  logic        phy_ready,
  output logic        phy_master_ack,
  input  logic        phy_slave_ack,
  output logic [7:0]  phy_data_from_master,
  input  logic [7:0]  phy_data_from_slave
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_ADRH, S_ADRL, S_WDATA,
    S_RSTART, S_DEVR, S_RDATA, S_STOP, S_FIN
  } state_t;

  state_t      state_r, state_s;
  logic        wait_r, wait_s;
  logic        is_read_r, is_read_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        err_r, err_s;
  logic [15:0] cnt_r, cnt_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic [7:0]  rd_data_r, rd_data_s;
  logic        start_r, start_s;
  logic        stop_r, stop_s;
  logic        write_r, write_s;
  logic        read_r, read_s;
  logic        mack_r, mack_s;
  logic [7:0]  dfm_r, dfm_s;
  logic        nack_s;

  assign busy                 = busy_r;
  assign done                 = done_r;
  assign error                = error_r;
  assign rd_data              = rd_data_r;
  assign phy_start_req        = start_r;
  assign phy_stop_req         = stop_r;
  assign phy_write_req        = write_r;
  assign phy_read_req         = read_r;
  assign phy_master_ack       = mack_r;
  assign phy_data_from_master = dfm_r;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      wait_r    <= 1'b0;
      is_read_r <= 1'b0;
      addr_r    <= 16'h0000;
      wdata_r   <= 8'h00;
      err_r     <= 1'b0;
      cnt_r     <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      rd_data_r <= 8'h00;
      start_r   <= 1'b0;
      stop_r    <= 1'b0;
      write_r   <= 1'b0;
      read_r    <= 1'b0;
      mack_r    <= 1'b0;
      dfm_r     <= 8'hFF;
    end else begin
      state_r   <= state_s;
      wait_r    <= wait_s;
      is_read_r <= is_read_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      err_r     <= err_s;
      cnt_r     <= cnt_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      error_r   <= error_s;
      rd_data_r <= rd_data_s;
      start_r   <= start_s;
      stop_r    <= stop_s;
      write_r   <= write_s;
      read_r    <= read_s;
      mack_r    <= mack_s;
      dfm_r     <= dfm_s;
    end
  end

  // Next-state and next-output logic; requests default low so they pulse for one cycle
  always_comb begin
    state_s   = state_r;
    wait_s    = wait_r;
    is_read_s = is_read_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    err_s     = err_r;
    cnt_s     = cnt_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    error_s   = 1'b0;
    rd_data_s = rd_data_r;
    start_s   = 1'b0;
    stop_s    = 1'b0;
    write_s   = 1'b0;
    read_s    = 1'b0;
    mack_s    = mack_r;
    dfm_s     = dfm_r;
    nack_s    = ~phy_slave_ack;

    case (state_r)
      S_IDLE: begin
        wait_s = 1'b0;
        // busy_r still high here means this is the done cycle; hold off one more clock
        if (!busy_r && (cmd_write || cmd_read)) begin
          state_s   = S_START;
          is_read_s = ~cmd_write;
          addr_s    = mem_addr;
          wdata_s   = wr_data;
          busy_s    = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      S_FIN: begin
        done_s  = 1'b1;
        error_s = err_r;
        err_s   = 1'b0;
        wait_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        if (!wait_r) begin
          wait_s = 1'b1;
          cnt_s  = 16'd0;
          case (state_r)
            S_START, S_RSTART: start_s = 1'b1;
            S_DEVW:  begin write_s = 1'b1; dfm_s = {DEV_ADDR, 1'b0}; end
            S_ADRH:  begin write_s = 1'b1; dfm_s = addr_r[15:8]; end
            S_ADRL:  begin write_s = 1'b1; dfm_s = addr_r[7:0]; end
            S_WDATA: begin write_s = 1'b1; dfm_s = wdata_r; end
            S_DEVR:  begin write_s = 1'b1; dfm_s = {DEV_ADDR, 1'b1}; end
            S_RDATA: begin read_s = 1'b1; mack_s = 1'b0; end
            S_STOP:  stop_s = 1'b1;
            default: state_s = S_IDLE;
          endcase
        end else if (phy_ready) begin
          wait_s = 1'b0;
          case (state_r)
            S_START: state_s = S_DEVW;
            S_DEVW: begin
              if (nack_s) begin
                err_s   = 1'b1;
                state_s = S_STOP;
              end else if (ADDR_BYTES == 1) begin
                state_s = S_ADRL;
              end else begin
                state_s = S_ADRH;
              end
            end
            S_ADRH: begin
              if (nack_s) begin
                err_s   = 1'b1;
                state_s = S_STOP;
              end else begin
                state_s = S_ADRL;
              end
            end
            S_ADRL: begin
              if (nack_s) begin
                err_s   = 1'b1;
                state_s = S_STOP;
              end else if (is_read_r) begin
                state_s = S_RSTART;
              end else begin
                state_s = S_WDATA;
              end
            end
            S_WDATA: begin
              err_s   = err_r | nack_s;
              state_s = S_STOP;
            end
            S_RSTART: state_s = S_DEVR;
            S_DEVR: begin
              if (nack_s) begin
                err_s   = 1'b1;
                state_s = S_STOP;
              end else begin
                state_s = S_RDATA;
              end
            end
            S_RDATA: begin
              rd_data_s = phy_data_from_slave;
              state_s   = S_STOP;
            end
            S_STOP:  state_s = S_FIN;
            default: state_s = S_IDLE;
          endcase
        end else if (cnt_r >= TIMEOUT - 16'd1) begin
          // PHY is unresponsive: skip the stop, it would hang the same way
          err_s   = 1'b1;
          wait_s  = 1'b0;
          state_s = S_FIN;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Bench for i2c_eeprom_ctrl: behavioural PHY/EEPROM model logging every primitive,
// a table of write/read vectors, and directed timeout, collision and reset sequences.
module tb_i2c_eeprom_ctrl;

  localparam logic [15:0] TMO = 16'd8191;
  localparam logic [0:5][11:0] W5 = {12'h100, 12'h2A0, 12'h200, 12'h242, 12'h299, 12'h400};
  localparam logic [0:7][11:0] R6 = {12'h100, 12'h2A0, 12'h200, 12'h201,
                                     12'h100, 12'h2A1, 12'h300, 12'h400};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_write = 1'b0;
  logic        cmd_read = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic        busy, done, error;
  logic [7:0]  rd_data;
  logic        phy_start_req, phy_stop_req, phy_write_req, phy_read_req;
  logic        phy_ready = 1'b0;
  logic        phy_master_ack;
  logic        phy_slave_ack = 1'b1;
  logic [7:0]  phy_data_from_master;
  logic [7:0]  phy_data_from_slave = 8'h00;

  i2c_eeprom_ctrl #(.DEV_ADDR(7'h50), .ADDR_BYTES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .mem_addr(mem_addr), .wr_data(wr_data), .busy(busy), .done(done), .error(error),
    .rd_data(rd_data), .phy_start_req(phy_start_req), .phy_stop_req(phy_stop_req),
    .phy_write_req(phy_write_req), .phy_read_req(phy_read_req), .phy_ready(phy_ready),
    .phy_master_ack(phy_master_ack), .phy_slave_ack(phy_slave_ack),
    .phy_data_from_master(phy_data_from_master), .phy_data_from_slave(phy_data_from_slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model config (written by the test only)
  int          cfg_nack = -1;
  logic        cfg_hang = 1'b0;
  logic [7:0]  cfg_sbyte = 8'h00;

  // Primitive log: {kind, data}; 1=start 2=write 3=read(master_ack) 4=stop
  logic [11:0] log_code [0:255];
  int          log_cyc [0:255];
  int          log_n = 0;
  int          done_cnt = 0;
  int          hold_viol = 0;
  int          pend = 0;
  int          wr_idx = 0;
  logic        ack_v = 1'b1;
  logic        prev_req = 1'b0;
  logic        req_any;

  always @(negedge clk) begin
    phy_ready = 1'b0;
    req_any = phy_start_req | phy_stop_req | phy_write_req | phy_read_req;
    if (rst) begin
      pend = 0;
      wr_idx = 0;
      prev_req = 1'b0;
    end else begin
      if (req_any && prev_req) hold_viol++;
      prev_req = req_any;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          phy_ready = 1'b1;
          phy_slave_ack = ack_v;
          phy_data_from_slave = cfg_sbyte;
        end
      end
      if (req_any && log_n < 256) begin
        if (phy_start_req)      log_code[log_n] = 12'h100;
        else if (phy_write_req) log_code[log_n] = {4'h2, phy_data_from_master};
        else if (phy_read_req)  log_code[log_n] = {4'h3, 7'h00, phy_master_ack};
        else                    log_code[log_n] = 12'h400;
        log_cyc[log_n] = cyc;
        log_n++;
        ack_v = 1'b1;
        if (phy_write_req) begin
          ack_v = (wr_idx != cfg_nack);
          wr_idx++;
        end
        if (!cfg_hang) pend = 3;
      end
      if (done) begin
        done_cnt++;
        wr_idx = 0;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    cmd_write = w;
    cmd_read  = r;
    mem_addr  = a;
    wr_data   = d;
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_read  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic got, output int at);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        at  = cyc;
      end
    end
  endtask

  typedef struct packed {
    logic             is_wr;
    logic [15:0]      addr;
    logic [7:0]       wdata;
    logic [7:0]       nack;   // index of written byte the slave NACKs, 8'hFF = none
    logic [7:0]       sbyte;
    logic [3:0]       n;
    logic [0:7][11:0] tr;
    logic             exp_err;
    logic [7:0]       exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic got;
    int   at;
    int   base;
    int   dc0;

    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'hFF, 8'h00, 4'd6,
                {12'h100, 12'h2A0, 12'h212, 12'h234, 12'h2A5, 12'h400, 12'h000, 12'h000}, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 16'h00FF, 8'h00, 8'hFF, 8'h3C, 4'd8,
                {12'h100, 12'h2A0, 12'h200, 12'h2FF, 12'h100, 12'h2A1, 12'h300, 12'h400}, 1'b0, 8'h3C};
    vecs[2] = '{1'b1, 16'h0010, 8'h77, 8'h00, 8'h00, 4'd3,
                {12'h100, 12'h2A0, 12'h400, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 16'hABCD, 8'h00, 8'h02, 8'h5A, 4'd5,
                {12'h100, 12'h2A0, 12'h2AB, 12'h2CD, 12'h400, 12'h000, 12'h000, 12'h000}, 1'b1, 8'h3C};
    vecs[4] = '{1'b0, 16'h7F80, 8'h00, 8'hFF, 8'hC3, 4'd8,
                {12'h100, 12'h2A0, 12'h27F, 12'h280, 12'h100, 12'h2A1, 12'h300, 12'h400}, 1'b0, 8'hC3};
    vecs[5] = '{1'b1, 16'hFFFF, 8'h00, 8'h03, 8'h00, 4'd6,
                {12'h100, 12'h2A0, 12'h2FF, 12'h2FF, 12'h200, 12'h400, 12'h000, 12'h000}, 1'b1, 8'hC3};
    vecs[6] = '{1'b0, 16'h8000, 8'h00, 8'h03, 8'h99, 4'd7,
                {12'h100, 12'h2A0, 12'h280, 12'h200, 12'h100, 12'h2A1, 12'h400, 12'h000}, 1'b1, 8'hC3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_reqs", {phy_start_req, phy_stop_req, phy_write_req, phy_read_req}, 4'h0);
    chk("rst_mack", phy_master_ack, 1'b0);
    chk("rst_dfm", phy_data_from_master, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      cfg_nack  = (vecs[v].nack == 8'hFF) ? -1 : int'(vecs[v].nack);
      cfg_sbyte = vecs[v].sbyte;
      base = log_n;
      issue(vecs[v].is_wr, ~vecs[v].is_wr, vecs[v].addr, vecs[v].wdata);
      wait_done(300, got, at);
      chk($sformatf("v%0d_done", v), got, 1'b1);
      chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d_rd_data", v), rd_data, vecs[v].exp_rd);
      chk($sformatf("v%0d_busy_at_done", v), busy, 1'b1);
      chk($sformatf("v%0d_trace_len", v), log_n - base, vecs[v].n);
      for (int i = 0; i < int'(vecs[v].n); i++)
        if (base + i < log_n)
          chk($sformatf("v%0d_trace%0d", v, i), log_code[base + i], vecs[v].tr[i]);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", v), busy, 1'b0);
      chk($sformatf("v%0d_error_pulse", v), error, 1'b0);
    end

    // PHY never answers the start: abort after TIMEOUT, no stop
    cfg_nack = -1;
    cfg_hang = 1'b1;
    base = log_n;
    issue(1'b1, 1'b0, 16'h0020, 8'h11);
    wait_done(9000, got, at);
    chk("tmo_done", got, 1'b1);
    chk("tmo_error", error, 1'b1);
    chk("tmo_trace_len", log_n - base, 1);
    if (base < log_n) begin
      chk("tmo_first_is_start", log_code[base], 12'h100);
      chk("tmo_latency", at - log_cyc[base], int'(TMO) + 1);
    end
    chk("tmo_rd_data_kept", rd_data, 8'hC3);
    cfg_hang = 1'b0;
    @(negedge clk);

    // Write and read together, then a read while busy: only the write runs
    base = log_n;
    dc0  = done_cnt;
    issue(1'b1, 1'b1, 16'h0042, 8'h99);
    repeat (3) @(negedge clk);
    cmd_read = 1'b1;
    mem_addr = 16'h0100;
    @(negedge clk);
    cmd_read = 1'b0;
    wait_done(300, got, at);
    chk("coll_done", got, 1'b1);
    chk("coll_error", error, 1'b0);
    repeat (40) @(negedge clk);
    chk("coll_done_count", done_cnt - dc0, 1);
    chk("coll_trace_len", log_n - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < log_n) chk($sformatf("coll_trace%0d", i), log_code[base + i], W5[i]);
    chk("coll_busy_idle", busy, 1'b0);

    // Reset while waiting on the low address byte
    cfg_sbyte = 8'h6E;
    base = log_n;
    issue(1'b1, 1'b0, 16'h5678, 8'h3A);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (log_n >= base + 4) got = 1'b1;
    end
    chk("mid_reached_adrl", got, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_done_error", {done, error}, 2'b00);
    chk("mid_reqs", {phy_start_req, phy_stop_req, phy_write_req, phy_read_req}, 4'h0);
    chk("mid_rd_data", rd_data, 8'h00);
    chk("mid_mack", phy_master_ack, 1'b0);
    chk("mid_dfm", phy_data_from_master, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = log_n;
    issue(1'b0, 1'b1, 16'h0001, 8'h00);
    wait_done(300, got, at);
    chk("post_rst_done", got, 1'b1);
    chk("post_rst_error", error, 1'b0);
    chk("post_rst_rd_data", rd_data, 8'h6E);
    chk("post_rst_trace_len", log_n - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < log_n) chk($sformatf("post_rst_trace%0d", i), log_code[base + i], R6[i]);

    @(negedge clk);
    chk("req_single_cycle", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
